seq_gen_prog: RTL and testbench
===============================

Name: seq_gen_prog

Overview:
- Parametrised successor of the board-level Fibonacci/timer sequence generator.
- One engine produces either a Fibonacci sequence or an up-counting timer, WIDTH bits wide.
- Step rate is runtime-programmable through an internal clock-enable divider, replacing the separate divided clock.
- Sits between the button edge detectors and the display driver/LED logic. Provides value, per-step valid pulse, parity and state.

Parameters:
- WIDTH, 16, width of the output value.
- PROG_W, 3, width of the rate-select input.
- DIV_BASE, 4, clock cycles per step at prog_reg=0; the step period is DIV_BASE << prog_reg cycles.
- TIMER_MAX, 2**WIDTH-1, terminal count of timer mode.
- PROG_RST, 3, reset value of prog_reg.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_f  in  1  one-cycle pulse: start Fibonacci mode.
- start_t  in  1  one-cycle pulse: start timer mode.
- stop_f_t  in  1  one-cycle pulse: stop the running mode.
- update  in  1  one-cycle pulse: load prog into prog_reg.
- prog  in  PROG_W  rate select, sampled on update.
- value  out  WIDTH  current sequence value.
- valid  out  1  one-cycle pulse when value is (re)written.
- parity  out  1  XOR reduction of value, registered together with value.
- state  out  3  IDLE=0, FIB=1, TIMER=2, DONE=3, PAUSE=4.

Behaviour:
- Reset (reset=0, async): state=IDLE, value=0, valid=0, parity=0, prog_reg=PROG_RST, tick counter=0, Fibonacci registers cleared. Effective immediately, including mid-sequence.
- Tick generator: a counter runs only in FIB/TIMER and emits tick every DIV_BASE<<prog_reg cycles. Counter clears on any start. First tick comes DIV_BASE<<prog_reg cycles after the start edge.
- Input priority in the same cycle: stop_f_t > start_f > start_t. update is independent of the other inputs.
- update: accepted only in IDLE or DONE (and PAUSE when compiled in); prog_reg=prog from the next cycle. Ignored in FIB/TIMER.
- IDLE:
  - start_f -> FIB; start_t -> TIMER.
  - value=0 and valid=1 on the cycle after the start edge (1-cycle latency).
- FIB:
  - Internal registers: value and f1 (f1=1 on entry).
  - On tick: value<=f1; f1<=value+f1, summed at WIDTH+1 bits.
  - A sum overflowing WIDTH bits sets sat and is not stored.
  - A tick while sat=1 -> DONE; value holds, no valid pulse.
  - Emitted sequence: 0,1,1,2,3,5,...
- TIMER:
  - On tick: value<=value+1 with valid=1.
  - A tick with value==TIMER_MAX -> DONE; value holds, no wrap.
- FIB/TIMER:
  - stop_f_t -> IDLE; value holds.
  - start_f/start_t restart the named mode from 0 (mode switch allowed).
- DONE: holds value. start_f/start_t restart; stop_f_t -> IDLE.
- valid is high for exactly one cycle per value write and is 0 otherwise.
- parity always equals ^value.

Optional Feature:
- Macro: SEQ_GEN_PAUSE_EN.
- Defined:
  - stop_f_t in FIB/TIMER -> PAUSE; value and tick counter are frozen.
  - stop_f_t in PAUSE resumes the saved mode with the counter continuing from its frozen count.
  - start_f/start_t in PAUSE restart from 0.
- Undefined:
  - stop_f_t -> IDLE as described above.
  - The PAUSE encoding is never produced.

Test Plan (WIDTH=8, DIV_BASE=4):
1. Reset low mid-FIB -> immediately value=0, state=0, parity=0; after release, update with prog=0 loads prog_reg=0 (step every 4 cycles).
2. prog_reg=0, pulse start_f -> value 0,1,1,2,3,5,8,13,21,34,55,89,144,233 with valid pulses spaced 4 cycles apart. The 14th tick gives state=DONE, value=233, parity=1, no valid pulse.
3. prog_reg=2 (16-cycle step), start_t, stop_f_t after 50 cycles -> value=3, state=IDLE; value holds for 100 further cycles with valid=0.
4. In TIMER, update with prog=0 is ignored: step spacing stays 16 cycles. After stop, the same update takes effect and the next start_t steps every 4 cycles.
5. start_f, stop_f_t and update asserted in the same cycle while in FIB -> state=IDLE, value held. The update is ignored because the engine was in FIB, so prog_reg is unchanged.
6. TIMER_MAX=5, start_t -> values 0..5, next tick -> DONE with value=5. With SEQ_GEN_PAUSE_EN defined, stop at value 2 -> state=4; second stop resumes and reaches 3 after the remaining tick cycles.

Source files
------------

// File: rtl/seq_gen_prog_if.sv
// Control/status bundle for seq_gen_prog: button pulses in, sequence value and status out.
// Build option SEQ_GEN_PAUSE_EN (in seq_gen_prog) does not change this bundle.
interface seq_gen_prog_if #(
    parameter int WIDTH  = 16,
    parameter int PROG_W = 3
);
    // Handshake: start_f/start_t/stop_f_t/update are one-cycle pulses sampled on the rising
    // clock edge with no ready/backpressure; valid is a one-cycle pulse marking each new value.
    logic              start_f;
    logic              start_t;
    logic              stop_f_t;
    logic              update;
    logic [PROG_W-1:0] prog;
    logic [WIDTH-1:0]  value;
    logic              valid;
    logic              parity;
    logic [2:0]        state;

    modport master (
        output start_f, start_t, stop_f_t, update, prog,
        input  value, valid, parity, state
    );

    modport slave (
        input  start_f, start_t, stop_f_t, update, prog,
        output value, valid, parity, state
    );
endinterface

// File: rtl/seq_gen_prog.sv
// Fibonacci / up-counting timer engine with a programmable clock-enable step rate.
// Optional pause/resume on stop_f_t is compiled in with `define SEQ_GEN_PAUSE_EN.
module seq_gen_prog #(
    parameter int                WIDTH     = 16,
    parameter int                PROG_W    = 3,
    parameter int                DIV_BASE  = 4,
    parameter logic [WIDTH-1:0]  TIMER_MAX = {WIDTH{1'b1}},
    parameter logic [PROG_W-1:0] PROG_RST  = PROG_W'(3)
) (
    input logic          clock,
    input logic          reset,
    seq_gen_prog_if.slave bus
);
    localparam int MAX_P = DIV_BASE << ((1 << PROG_W) - 1);
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIB   = 3'd1,
        S_TIMER = 3'd2,
        S_DONE  = 3'd3,
        S_PAUSE = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [WIDTH-1:0]  f1_q, f1_d;
    logic              sat_q, sat_d;
    logic              valid_q, valid_d;
    logic              parity_q, parity_d;
    logic [PROG_W-1:0] prog_q, prog_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    period_m1;
    logic [WIDTH:0]    fib_sum;
    logic              running;
    logic              tick;
    logic              upd_ok;
`ifdef SEQ_GEN_PAUSE_EN
    state_e            mode_q, mode_d;
`endif

    assign period_m1 = ((CNT_W+1)'(DIV_BASE) << prog_q) - (CNT_W+1)'(1);
    assign running   = (state_q == S_FIB) || (state_q == S_TIMER);
    // ">=" rather than "==" so a rate change made while paused cannot strand the counter
    assign tick      = running && ({1'b0, cnt_q} >= period_m1);
    assign fib_sum   = {1'b0, value_q} + {1'b0, f1_q};

    always_comb begin
        state_d  = state_q;
        value_d  = value_q;
        f1_d     = f1_q;
        sat_d    = sat_q;
        valid_d  = 1'b0;
        prog_d   = prog_q;
        cnt_d    = cnt_q;
`ifdef SEQ_GEN_PAUSE_EN
        mode_d   = mode_q;
`endif
        upd_ok = (state_q == S_IDLE) || (state_q == S_DONE);
`ifdef SEQ_GEN_PAUSE_EN
        if (state_q == S_PAUSE) upd_ok = 1'b1;
`endif
        if (bus.update && upd_ok) prog_d = bus.prog;

        if (bus.stop_f_t) begin
            case (state_q)
                S_FIB, S_TIMER: begin
`ifdef SEQ_GEN_PAUSE_EN
                    mode_d  = state_q;
                    state_d = S_PAUSE;
`else
                    state_d = S_IDLE;
`endif
                end
                S_DONE: state_d = S_IDLE;
`ifdef SEQ_GEN_PAUSE_EN
                S_PAUSE: state_d = mode_q;
`endif
                default: ;
            endcase
        end else if (bus.start_f || bus.start_t) begin
            state_d = bus.start_f ? S_FIB : S_TIMER;
            value_d = '0;
            f1_d    = WIDTH'(1);
            sat_d   = 1'b0;
            valid_d = 1'b1;
            cnt_d   = '0;
        end else if (running) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (tick) begin
                if (state_q == S_FIB) begin
                    if (sat_q) begin
                        state_d = S_DONE;
                    end else begin
                        value_d = f1_q;
                        valid_d = 1'b1;
                        // an overflowing sum is never stored; the next tick ends the run
                        if (fib_sum[WIDTH]) sat_d = 1'b1;
                        else                f1_d  = fib_sum[WIDTH-1:0];
                    end
                end else begin
                    if (value_q == TIMER_MAX) begin
                        state_d = S_DONE;
                    end else begin
                        value_d = value_q + WIDTH'(1);
                        valid_d = 1'b1;
                    end
                end
            end
        end
        parity_d = ^value_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            value_q  <= '0;
            f1_q     <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
            parity_q <= 1'b0;
            prog_q   <= PROG_RST;
            cnt_q    <= '0;
`ifdef SEQ_GEN_PAUSE_EN
            mode_q   <= S_IDLE;
`endif
        end else begin
            state_q  <= state_d;
            value_q  <= value_d;
            f1_q     <= f1_d;
            sat_q    <= sat_d;
            valid_q  <= valid_d;
            parity_q <= parity_d;
            prog_q   <= prog_d;
            cnt_q    <= cnt_d;
`ifdef SEQ_GEN_PAUSE_EN
            mode_q   <= mode_d;
`endif
        end
    end

    assign bus.value  = value_q;
    assign bus.valid  = valid_q;
    assign bus.parity = parity_q;
    assign bus.state  = state_q;
endmodule

// File: tb/tb_seq_gen_prog.sv
// Bench for seq_gen_prog (WIDTH=8, DIV_BASE=4, TIMER_MAX=5): directed plan steps then random runs
// compared cycle by cycle against a tick-count model of the emitted sequence.
module tb_seq_gen_prog;
    localparam int         W       = 8;
    localparam int         TMAX    = 5;
    localparam logic [2:0] IDLE_S  = 3'd0;
    localparam logic [2:0] FIB_S   = 3'd1;
    localparam logic [2:0] TIMER_S = 3'd2;
    localparam logic [2:0] DONE_S  = 3'd3;
`ifdef SEQ_GEN_PAUSE_EN
    localparam logic [2:0] STOP_S  = 3'd4;
`else
    localparam logic [2:0] STOP_S  = 3'd0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    seq_gen_prog_if #(.WIDTH(W), .PROG_W(3)) bus();

    seq_gen_prog #(
        .WIDTH(W), .PROG_W(3), .DIV_BASE(4), .TIMER_MAX(8'd5), .PROG_RST(3'd3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int             checks   = 0;
    int             failures = 0;
    int             cur_pr;
    logic [W-1:0]   fib_q[$];
    logic [W-1:0]   last_v;
    logic [2:0]     last_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] s, input logic [W-1:0] v,
                           input logic vl);
        chk({tag, ".state"},  32'(bus.state),  32'(s));
        chk({tag, ".value"},  32'(bus.value),  32'(v));
        chk({tag, ".valid"},  32'(bus.valid),  32'(vl));
        chk({tag, ".parity"}, 32'(bus.parity), 32'(^v));
    endtask

    // one clock: outputs of the edge are settled afterwards, pulse inputs drop
    task automatic cyc();
        @(posedge clock);
        #1;
        bus.start_f  = 1'b0;
        bus.start_t  = 1'b0;
        bus.stop_f_t = 1'b0;
        bus.update   = 1'b0;
    endtask

    // k cycles after the start edge, k/p ticks have happened; tick n emits the n-th list entry
    function automatic void model(input int mode, input int p, input int k,
                                  output logic [W-1:0] v, output logic [2:0] s, output logic vl);
        int n;
        int last;
        n    = k / p;
        last = (mode == 0) ? fib_q.size() - 1 : TMAX;
        if (n <= last) begin
            v  = (mode == 0) ? fib_q[n] : W'(n);
            s  = (mode == 0) ? FIB_S : TIMER_S;
            vl = (k % p == 0);
        end else begin
            v  = (mode == 0) ? fib_q[last] : W'(TMAX);
            s  = DONE_S;
            vl = 1'b0;
        end
    endfunction

    task automatic run_seq(input int mode, input int k_stop, input int upd_at, input int upd_prog);
        int           p;
        string        tag;
        logic [W-1:0] v;
        logic [2:0]   s;
        logic         vl;
        p   = 4 << cur_pr;
        tag = (mode == 0) ? "fib" : "tmr";
        if (mode == 0) bus.start_f = 1'b1;
        else           bus.start_t = 1'b1;
        for (int k = 0; k <= k_stop; k++) begin
            cyc();
            model(mode, p, k, v, s, vl);
            chk_all(tag, s, v, vl);
            if (k == upd_at) begin
                bus.update = 1'b1;
                bus.prog   = 3'(upd_prog);
                if (s == DONE_S) cur_pr = upd_prog;
            end
        end
        last_v = v;
        last_s = s;
    endtask

    task automatic stop_chk(input bit with_start, input bit with_upd, input int upd_prog,
                            input int hold);
        logic [2:0] es;
        bus.stop_f_t = 1'b1;
        if (with_start) bus.start_f = 1'b1;
        if (with_upd) begin
            bus.update = 1'b1;
            bus.prog   = 3'(upd_prog);
            if (last_s == DONE_S || last_s == IDLE_S) cur_pr = upd_prog;
        end
        es = (last_s == DONE_S) ? IDLE_S : STOP_S;
        cyc();
        chk_all("stop", es, last_v, 1'b0);
        for (int i = 0; i < hold; i++) begin
            cyc();
            chk_all("hold", es, last_v, 1'b0);
        end
        last_s = es;
    endtask

    task automatic set_prog(input int pr);
        bus.update = 1'b1;
        bus.prog   = 3'(pr);
        cyc();
        cur_pr = pr;
    endtask

    initial begin
        int a;
        int b;
        int t;
        bus.start_f  = 1'b0;
        bus.start_t  = 1'b0;
        bus.stop_f_t = 1'b0;
        bus.update   = 1'b0;
        bus.prog     = 3'd0;
        a = 0;
        b = 1;
        fib_q.push_back(W'(a));
        while (b < (1 << W)) begin
            fib_q.push_back(W'(b));
            t = a + b;
            a = b;
            b = t;
        end

        // reset state, then the reset rate (prog_reg=3 -> 32-cycle step)
        repeat (3) cyc();
        chk_all("reset", IDLE_S, '0, 1'b0);
        #2 reset = 1'b1;
        cyc();
        cur_pr = 3;
        last_s = IDLE_S;
        run_seq(1, 70, -1, 0);
        stop_chk(1'b0, 1'b0, 0, 3);

        // asynchronous reset in the middle of a Fibonacci run
        run_seq(0, 40, -1, 0);
        #2 reset = 1'b0;
        #1 chk_all("async_rst", IDLE_S, '0, 1'b0);
        cyc();
        chk_all("rst_held", IDLE_S, '0, 1'b0);
        #2 reset = 1'b1;
        cyc();
        cur_pr = 3;
        last_s = IDLE_S;
        set_prog(0);

        // full Fibonacci run to DONE (233) at a 4-cycle step
        run_seq(0, 14 * 4 + 3, -1, 0);
        stop_chk(1'b0, 1'b0, 0, 2);

        // 16-cycle timer, update while running is ignored, stop at 50 cycles, long hold
        set_prog(2);
        run_seq(1, 49, 5, 0);
        stop_chk(1'b0, 1'b0, 0, 100);
        set_prog(0);
        run_seq(1, 13, -1, 0);
        stop_chk(1'b0, 1'b0, 0, 2);

        // stop + start_f + update together during FIB
        run_seq(0, 10, -1, 0);
        stop_chk(1'b1, 1'b1, 1, 3);
        run_seq(1, 9, -1, 0);
        stop_chk(1'b0, 1'b0, 0, 2);

        // timer to its terminal count
        run_seq(1, 30, -1, 0);
        stop_chk(1'b0, 1'b0, 0, 2);

`ifdef SEQ_GEN_PAUSE_EN
        // pause at 2, resume: 9 running edges were used, the tick lands 3 edges after resume
        run_seq(1, 9, -1, 0);
        stop_chk(1'b0, 1'b0, 0, 5);
        bus.stop_f_t = 1'b1;
        cyc();
        chk_all("resume", TIMER_S, 8'd2, 1'b0);
        cyc();
        chk_all("resume1", TIMER_S, 8'd2, 1'b0);
        cyc();
        chk_all("resume2", TIMER_S, 8'd2, 1'b0);
        cyc();
        chk_all("resume3", TIMER_S, 8'd3, 1'b1);
        last_v = 8'd3;
        last_s = TIMER_S;
        stop_chk(1'b0, 1'b0, 0, 2);
`endif

        // random modes, rates, stop points, stray updates and direct restarts
        for (int it = 0; it < 12; it++) begin
            int mode;
            int p;
            int ks;
            int ua;
            int up;
            mode = $urandom_range(0, 1);
            p    = 4 << cur_pr;
            ks   = $urandom_range(0, 16 * p);
            ua   = $urandom_range(0, ks);
            up   = $urandom_range(0, 2);
            run_seq(mode, ks, ua, up);
            if ($urandom_range(0, 1) == 1) begin
                stop_chk(1'b0, 1'b0, 0, $urandom_range(1, 4));
                set_prog($urandom_range(0, 2));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
